// File: rtl/axi_wr_slave.sv
// -----------------------------------------------------------------------------
// axi_wr_slave
//
// AXI write-channel responder. Accepts one burst at a time on AW, absorbs
// exactly len+1 W beats, writes writable beats into a word-wide SRAM port one
// cycle after each W handshake, and returns a single B response per burst.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   aw_valid/aw_ready        AW handshake
//   aw_addr/burst/len/size/id  burst descriptor (captured on AW handshake)
//   w_valid/w_ready          W handshake
//   w_data/w_strb/w_last     write beat payload
//   b_valid/b_ready          B handshake
//   b_resp/b_id              response code (OKAY/SLVERR/DECERR) and echoed ID
//   mem_we/mem_addr/mem_wdata/mem_wstrb  registered SRAM write port
// -----------------------------------------------------------------------------
module axi_wr_slave #(
   parameter int DATA_W = 256,
   parameter int MEM_AW = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                aw_valid,
   output logic                aw_ready,
   input  logic [31:0]         aw_addr,
   input  logic [1:0]          aw_burst,
   input  logic [7:0]          aw_len,
   input  logic [2:0]          aw_size,
   input  logic [7:0]          aw_id,
   input  logic                w_valid,
   output logic                w_ready,
   input  logic [DATA_W-1:0]   w_data,
   input  logic [DATA_W/8-1:0] w_strb,
   input  logic                w_last,
   output logic                b_valid,
   input  logic                b_ready,
   output logic [1:0]          b_resp,
   output logic [7:0]          b_id,
   output logic                mem_we,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb
);

   localparam int SW = DATA_W / 8;

   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2} state_t;

   state_t              state_q, state_d;
   // Current beat address kept as a 32-byte word index (byte addr >> 5), so
   // a +1 increment wraps exactly like a 32-bit byte address.
   logic [26:0]         waddr_q, waddr_d;
   logic                fixed_q, fixed_d;
   logic                unsup_q, unsup_d;
   logic [7:0]          len_q, len_d;
   logic [7:0]          id_q, id_d;
   logic [7:0]          beat_q, beat_d;
   logic                slverr_q, slverr_d;
   logic                decerr_q, decerr_d;
   logic                b_valid_q, b_valid_d;
   logic [1:0]          b_resp_q, b_resp_d;
   logic [7:0]          b_id_q, b_id_d;
   logic                mem_we_q, mem_we_d;
   logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [SW-1:0]       mem_wstrb_q, mem_wstrb_d;

   logic in_range;
   logic is_last;

   // The start address is aligned down to a word, so the byte-lane bits of
   // aw_addr carry no information here.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^aw_addr[4:0];

   assign aw_ready  = (state_q == IDLE) & ~rst;
   assign w_ready   = (state_q == DATA) & ~rst;
   assign b_valid   = b_valid_q;
   assign b_resp    = b_resp_q;
   assign b_id      = b_id_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;

   // A word index is in range when every bit above the SRAM address is zero.
   assign in_range = ~|waddr_q[26:MEM_AW];
   assign is_last  = (beat_q == len_q);

   always_comb begin
      state_d     = state_q;
      waddr_d     = waddr_q;
      fixed_d     = fixed_q;
      unsup_d     = unsup_q;
      len_d       = len_q;
      id_d        = id_q;
      beat_d      = beat_q;
      slverr_d    = slverr_q;
      decerr_d    = decerr_q;
      b_valid_d   = b_valid_q;
      b_resp_d    = b_resp_q;
      b_id_d      = b_id_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;

      case (state_q)
         IDLE: begin
            if (aw_valid && aw_ready) begin
               waddr_d  = aw_addr[31:5];
               fixed_d  = (aw_burst == 2'd0);
               // Only FIXED/INCR at full bus width are served; anything
               // else is drained without writing and answered with SLVERR.
               unsup_d  = (aw_burst[1] == 1'b1) || (aw_size != 3'd5);
               slverr_d = unsup_d;
               decerr_d = 1'b0;
               len_d    = aw_len;
               id_d     = aw_id;
               beat_d   = 8'd0;
               state_d  = DATA;
            end
         end
         DATA: begin
            if (w_valid && w_ready) begin
               if (!in_range) begin
                  decerr_d = 1'b1;
               end else if (!unsup_q) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = waddr_q[MEM_AW-1:0];
                  mem_wdata_d = w_data;
                  mem_wstrb_d = w_strb;
               end
               // Beat count, not w_last, ends the burst; a disagreeing
               // w_last only flags the error.
               if (w_last != is_last) begin
                  slverr_d = 1'b1;
               end
               if (!fixed_q) begin
                  waddr_d = waddr_q + 27'd1;
               end
               beat_d = beat_q + 8'd1;
               if (is_last) begin
                  state_d   = RESP;
                  b_valid_d = 1'b1;
                  b_id_d    = id_q;
                  b_resp_d  = slverr_d ? 2'd2 : (decerr_d ? 2'd3 : 2'd0);
               end
            end
         end
         RESP: begin
            if (b_ready) begin
               b_valid_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         waddr_q     <= '0;
         fixed_q     <= 1'b0;
         unsup_q     <= 1'b0;
         len_q       <= '0;
         id_q        <= '0;
         beat_q      <= '0;
         slverr_q    <= 1'b0;
         decerr_q    <= 1'b0;
         b_valid_q   <= 1'b0;
         b_resp_q    <= '0;
         b_id_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
      end else begin
         state_q     <= state_d;
         waddr_q     <= waddr_d;
         fixed_q     <= fixed_d;
         unsup_q     <= unsup_d;
         len_q       <= len_d;
         id_q        <= id_d;
         beat_q      <= beat_d;
         slverr_q    <= slverr_d;
         decerr_q    <= decerr_d;
         b_valid_q   <= b_valid_d;
         b_resp_q    <= b_resp_d;
         b_id_q      <= b_id_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
      end
   end

endmodule

// File: tb/tb_axi_wr_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_slave
//
// Directed bench for axi_wr_slave. A transaction-level model tracks the burst
// in flight from the observed handshakes and predicts every output each
// cycle; directed tests additionally pin hand-computed write addresses and
// B responses.
// -----------------------------------------------------------------------------
module tb_axi_wr_slave;

   localparam int DATA_W = 256;
   localparam int MEM_AW = 10;
   localparam int SW     = DATA_W / 8;
   localparam logic [31:0] MEM_BYTES = 32'd32768;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              aw_valid = 1'b0;
   logic              aw_ready;
   logic [31:0]       aw_addr = '0;
   logic [1:0]        aw_burst = '0;
   logic [7:0]        aw_len = '0;
   logic [2:0]        aw_size = '0;
   logic [7:0]        aw_id = '0;
   logic              w_valid = 1'b0;
   logic              w_ready;
   logic [DATA_W-1:0] w_data = '0;
   logic [SW-1:0]     w_strb = '0;
   logic              w_last = 1'b0;
   logic              b_valid;
   logic              b_ready = 1'b1;
   logic [1:0]        b_resp;
   logic [7:0]        b_id;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [SW-1:0]     mem_wstrb;

   always #5 clk = ~clk;

   axi_wr_slave #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
      .clk(clk), .rst(rst),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
      .aw_burst(aw_burst), .aw_len(aw_len), .aw_size(aw_size), .aw_id(aw_id),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .w_strb(w_strb), .w_last(w_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int         wr_log[$];
   logic [9:0] b_log[$];
   logic       b_prev = 1'b0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- transaction model ----------------
   bit                m_started = 0;
   bit                m_busy = 0;
   bit                m_bpend = 0;
   bit                m_fixed = 0;
   bit                m_unsup = 0;
   bit                m_slv = 0;
   bit                m_dec = 0;
   logic [31:0]       m_start = '0;
   logic [31:0]       m_ba = '0;
   logic [7:0]        m_len = '0;
   logic [7:0]        m_id = '0;
   int                m_beat = 0;
   bit                exp_we = 0;
   logic [MEM_AW-1:0] exp_addr = '0;
   logic [DATA_W-1:0] exp_data = '0;
   logic [SW-1:0]     exp_strb = '0;
   logic [1:0]        exp_bresp = '0;

   initial forever begin
      @(posedge clk);
      m_started = 1;
      exp_we = 0;
      if (rst) begin
         m_busy  = 0;
         m_bpend = 0;
      end else if (m_busy) begin
         if (w_valid) begin
            m_ba = m_start + (m_fixed ? 32'd0 : 32'(m_beat) * 32'd32);
            if (m_ba >= MEM_BYTES) begin
               m_dec = 1;
            end else if (!m_unsup) begin
               exp_we   = 1;
               exp_addr = m_ba[MEM_AW+4:5];
               exp_data = w_data;
               exp_strb = w_strb;
            end
            if (w_last != (m_beat == int'(m_len))) m_slv = 1;
            if (m_beat == int'(m_len)) begin
               m_busy    = 0;
               m_bpend   = 1;
               exp_bresp = m_slv ? 2'd2 : (m_dec ? 2'd3 : 2'd0);
            end
            m_beat++;
         end
      end else if (m_bpend) begin
         if (b_ready) m_bpend = 0;
      end else if (aw_valid) begin
         m_busy  = 1;
         m_start = aw_addr & 32'hFFFF_FFE0;
         m_fixed = (aw_burst == 2'd0);
         m_unsup = (aw_burst > 2'd1) || (aw_size != 3'd5);
         m_slv   = m_unsup;
         m_dec   = 0;
         m_len   = aw_len;
         m_id    = aw_id;
         m_beat  = 0;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      #1;
      if (m_started) begin
         chk("aw_ready", aw_ready, !m_busy && !m_bpend && !rst);
         chk("w_ready", w_ready, m_busy && !rst);
         chk("b_valid", b_valid, m_bpend);
         if (m_bpend) begin
            chk("b_resp", b_resp, exp_bresp);
            chk("b_id", b_id, m_id);
         end
         chk("mem_we", mem_we, exp_we);
         if (exp_we) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wdata", mem_wdata, exp_data);
            chk("mem_wstrb", mem_wstrb, exp_strb);
         end
         if (mem_we) wr_log.push_back(int'(mem_addr));
         if (b_valid && !b_prev) b_log.push_back({b_resp, b_id});
         b_prev = b_valid;
      end
   end

   // ---------------- drivers (called at a negedge, return at a negedge) ----
   task automatic timeout(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got timeout expected handshake", nm);
   endtask

   task automatic do_aw(input logic [31:0] a, input logic [1:0] bu, input logic [7:0] l,
                        input logic [2:0] s, input logic [7:0] id, output int waits);
      bit ok = 0;
      waits    = -1;
      aw_addr  = a;
      aw_burst = bu;
      aw_len   = l;
      aw_size  = s;
      aw_id    = id;
      aw_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         #1;
         if (aw_ready) begin
            ok = 1;
            waits = t;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      aw_valid = 1'b0;
      if (!ok) timeout("aw_handshake");
   endtask

   task automatic send_beat(input logic [SW-1:0] strb, input bit last);
      bit ok = 0;
      for (int k = 0; k < DATA_W / 32; k++) w_data[k*32 +: 32] = $urandom();
      w_strb  = strb;
      w_last  = last;
      w_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         #1;
         if (w_ready) begin
            ok = 1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      if (!ok) timeout("w_handshake");
   endtask

   task automatic wait_b();
      bit ok = 0;
      for (int t = 0; t < 50; t++) begin
         #1;
         if (b_valid) begin
            ok = 1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      if (!ok) timeout("b_handshake");
   endtask

   task automatic run_burst(input logic [31:0] a, input logic [1:0] bu, input logic [7:0] l,
                            input logic [2:0] s, input logic [7:0] id,
                            input logic [SW-1:0] strb, input int lastpos, input bit do_wait);
      int waits;
      wr_log.delete();
      b_log.delete();
      do_aw(a, bu, l, s, id, waits);
      for (int i = 0; i <= int'(l); i++) send_beat(strb, i == lastpos);
      w_valid = 1'b0;
      w_last  = 1'b0;
      if (do_wait) begin
         wait_b();
         @(negedge clk);
      end
   endtask

   task automatic chk_writes(input string nm, input int n, input int base, input int step);
      chk({nm, " write count"}, wr_log.size(), n);
      for (int i = 0; i < n && i < wr_log.size(); i++)
         chk({nm, " write addr"}, wr_log[i], base + i * step);
   endtask

   task automatic chk_b(input string nm, input logic [1:0] resp, input logic [7:0] id);
      chk({nm, " b count"}, b_log.size(), 1);
      if (b_log.size() > 0) chk({nm, " b resp/id"}, b_log[0], {resp, id});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int waits;
      @(negedge clk);
      repeat (2) @(negedge clk);
      // reset state
      chk("rst aw_ready", aw_ready, 0);
      chk("rst w_ready", w_ready, 0);
      chk("rst b_valid", b_valid, 0);
      chk("rst b_resp", b_resp, 0);
      chk("rst b_id", b_id, 0);
      chk("rst mem_we", mem_we, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      chk("rst mem_wstrb", mem_wstrb, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle aw_ready", aw_ready, 1);

      // INCR, 4 beats from word 2
      run_burst(32'h0000_0040, 2'd1, 8'd3, 3'd5, 8'h5A, '1, 3, 1);
      chk_writes("incr", 4, 2, 1);
      chk_b("incr", 2'd0, 8'h5A);
      $display("[TB] incr burst done: %0d writes", wr_log.size());

      // FIXED, three writes to word 8 with partial strobes
      run_burst(32'h0000_0100, 2'd0, 8'd2, 3'd5, 8'h11, 32'hFFFF_0000, 2, 1);
      chk_writes("fixed", 3, 8, 0);
      chk_b("fixed", 2'd0, 8'h11);
      $display("[TB] fixed burst done: %0d writes", wr_log.size());

      // INCR crossing the top of memory
      run_burst(MEM_BYTES - 32'd64, 2'd1, 8'd3, 3'd5, 8'h22, '1, 3, 1);
      chk_writes("decerr", 2, 1022, 1);
      chk_b("decerr", 2'd3, 8'h22);
      $display("[TB] out-of-range burst done: %0d writes", wr_log.size());

      // WRAP burst
      run_burst(32'h0000_0080, 2'd2, 8'd1, 3'd5, 8'h33, '1, 1, 1);
      chk_writes("wrap", 0, 0, 1);
      chk_b("wrap", 2'd2, 8'h33);
      $display("[TB] wrap burst done: %0d writes", wr_log.size());

      // INCR with narrow size
      run_burst(32'h0000_0080, 2'd1, 8'd1, 3'd4, 8'h44, '1, 1, 1);
      chk_writes("size4", 0, 0, 1);
      chk_b("size4", 2'd2, 8'h44);
      $display("[TB] narrow burst done: %0d writes", wr_log.size());

      // early w_last
      run_burst(32'h0000_0200, 2'd1, 8'd2, 3'd5, 8'h55, '1, 1, 1);
      chk_writes("early_last", 3, 16, 1);
      chk_b("early_last", 2'd2, 8'h55);
      $display("[TB] early w_last burst done: %0d writes", wr_log.size());

      // same burst with B backpressure
      b_ready = 1'b0;
      run_burst(32'h0000_0200, 2'd1, 8'd2, 3'd5, 8'h66, '1, 1, 0);
      wait_b();
      for (int i = 0; i < 5; i++) begin
         chk("hold b_valid", b_valid, 1);
         chk("hold b_resp", b_resp, 2);
         chk("hold b_id", b_id, 8'h66);
         chk("hold aw_ready", aw_ready, 0);
         @(negedge clk);
      end
      b_ready = 1'b1;
      #1;
      chk("pre-hs aw_ready", aw_ready, 0);
      @(negedge clk);
      chk("post-hs aw_ready", aw_ready, 1);
      chk("post-hs b_valid", b_valid, 0);
      chk_writes("backpressure", 3, 16, 1);
      chk_b("backpressure", 2'd2, 8'h66);
      $display("[TB] backpressure burst done: %0d writes", wr_log.size());

      // unaligned start, single beat
      run_burst(32'h0000_006F, 2'd1, 8'd0, 3'd5, 8'h77, '1, 0, 1);
      chk_writes("len0", 1, 3, 1);
      chk_b("len0", 2'd0, 8'h77);
      $display("[TB] single-beat burst done: %0d writes", wr_log.size());

      // reset after the 2nd of 4 beats, then a fresh burst right away
      wr_log.delete();
      b_log.delete();
      do_aw(32'h0000_0400, 2'd1, 8'd3, 3'd5, 8'h88, waits);
      send_beat('1, 0);
      send_beat('1, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid-rst mem_we", mem_we, 0);
      chk("mid-rst w_ready", w_ready, 0);
      chk("mid-rst b_valid", b_valid, 0);
      chk("mid-rst mem_addr", mem_addr, 0);
      chk("mid-rst mem_wstrb", mem_wstrb, 0);
      rst = 1'b0;
      do_aw(32'h0000_0020, 2'd1, 8'd0, 3'd5, 8'h99, waits);
      chk("post-rst aw waits", waits, 0);
      send_beat('1, 1);
      w_valid = 1'b0;
      w_last  = 1'b0;
      wait_b();
      @(negedge clk);
      chk("rst writes count", wr_log.size(), 3);
      if (wr_log.size() == 3) begin
         chk("rst write 0", wr_log[0], 32);
         chk("rst write 1", wr_log[1], 33);
         chk("rst write 2", wr_log[2], 1);
      end
      chk_b("after_rst", 2'd0, 8'h99);
      $display("[TB] reset mid-burst done: %0d writes", wr_log.size());

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
